// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Definitions shared by the elevator controller and the car-mechanics
//   stage (elevator_body):
//     - 2-bit command encodings driven by the controller
//     - body state encoding
//     - small constant helper used for sizing counters
package elevator_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_UP    = 2'b01;
  localparam logic [1:0] CMD_DOWN  = 2'b10;
  localparam logic [1:0] CMD_SERVE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_MOVE_UP   = 2'b01,
    ST_MOVE_DOWN = 2'b10,
    ST_DOOR      = 2'b11
  } body_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// elevator_timer
//   Loadable down-counter shared by the travel and door phases of the car.
//   A load strobe captures load_value; otherwise the count decrements by one
//   per cycle and holds at zero (it never wraps).
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high (count -> 0)
//   load       in   load strobe, takes priority over decrement
//   load_value in   W-bit value captured on load
//   zero       out  high while the count is zero
module elevator_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/elevator_body.sv
// elevator_body
//   Car mechanics downstream of the elevator controller. Takes the 2-bit
//   command (idle/up/down/serve), moves the car one floor per travel
//   interval or runs a door-open cycle, and reports floor and a one-cycle
//   served pulse back to the controller.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   command      in   2-bit command from the controller (CMD_* encodings)
//   cur_floor    out  registered current floor, 0..N-1
//   served_pulse out  one-cycle pulse after a door cycle completes
//   door_open    out  high while in the door state
//   moving_up    out  high while travelling upward
//   moving_down  out  high while travelling downward
//   busy         out  high in any state other than idle
module elevator_body
  import elevator_pkg::*;
#(
  parameter int N             = 4,
  parameter int F_BITS        = $clog2(N),
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        command,
  output logic [F_BITS-1:0] cur_floor,
  output logic              served_pulse,
  output logic              door_open,
  output logic              moving_up,
  output logic              moving_down,
  output logic              busy
);

  localparam int TW = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
  // A settle length of zero still needs a one-bit register to hold 0.
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [TW-1:0]     TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0]     DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [F_BITS-1:0] TOP_FLOOR   = F_BITS'(N - 1);

  body_state_t       state_reg, state_next;
  logic [F_BITS-1:0] floor_reg, floor_next;
  logic              served_reg, served_next;
  logic [SW-1:0]     settle_reg, settle_next;

  logic              timer_load;
  logic [TW-1:0]     timer_load_value;
  logic              timer_zero;

  elevator_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_load_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      floor_reg  <= '0;
      served_reg <= 1'b0;
      settle_reg <= '0;
    end else begin
      state_reg  <= state_next;
      floor_reg  <= floor_next;
      served_reg <= served_next;
      settle_reg <= settle_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    floor_next       = floor_reg;
    served_next      = 1'b0;
    settle_next      = (settle_reg != '0) ? settle_reg - SW'(1) : settle_reg;
    timer_load       = 1'b0;
    timer_load_value = TRAVEL_LOAD;

    case (state_reg)
      ST_IDLE: begin
        case (command)
          CMD_SERVE: begin
            // Serve requests arriving while the controller is still
            // clearing the previous one are dropped.
            if (settle_reg == '0) begin
              state_next       = ST_DOOR;
              timer_load       = 1'b1;
              timer_load_value = DOOR_LOAD;
            end
          end
          CMD_UP: begin
            if (floor_reg < TOP_FLOOR) begin
              state_next = ST_MOVE_UP;
              timer_load = 1'b1;
            end
          end
          CMD_DOWN: begin
            if (floor_reg != '0) begin
              state_next = ST_MOVE_DOWN;
              timer_load = 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Travel is committed once started: command is not looked at here.
      ST_MOVE_UP: begin
        if (timer_zero) begin
          floor_next = floor_reg + F_BITS'(1);
          state_next = ST_IDLE;
        end
      end

      ST_MOVE_DOWN: begin
        if (timer_zero) begin
          floor_next = floor_reg - F_BITS'(1);
          state_next = ST_IDLE;
        end
      end

      ST_DOOR: begin
        if (timer_zero) begin
          state_next  = ST_IDLE;
          served_next = 1'b1;
          settle_next = SETTLE_LOAD;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign cur_floor    = floor_reg;
  assign served_pulse = served_reg;
  assign door_open    = (state_reg == ST_DOOR);
  assign moving_up    = (state_reg == ST_MOVE_UP);
  assign moving_down  = (state_reg == ST_MOVE_DOWN);
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_elevator_body.sv
// tb_elevator_body
//   Self-checking bench for elevator_body with N=4, TRAVEL_CYCLES=4,
//   DOOR_CYCLES=6, SETTLE_CYCLES=3. A behavioural model tracks the car as an
//   activity with a number of cycles left to run; every cycle the DUT
//   outputs are compared against it, and directed scenarios pin the timing
//   with hand-computed literals before a randomized phase.
module tb_elevator_body;

  localparam int N    = 4;
  localparam int FB   = 2;
  localparam int TRAV = 4;
  localparam int DOOR = 6;
  localparam int SETL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    command = 2'b00;
  logic [FB-1:0] cur_floor;
  logic          served_pulse;
  logic          door_open;
  logic          moving_up;
  logic          moving_down;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  elevator_body #(
    .N             (N),
    .F_BITS        (FB),
    .TRAVEL_CYCLES (TRAV),
    .DOOR_CYCLES   (DOOR),
    .SETTLE_CYCLES (SETL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .command      (command),
    .cur_floor    (cur_floor),
    .served_pulse (served_pulse),
    .door_open    (door_open),
    .moving_up    (moving_up),
    .moving_down  (moving_down),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_act: 0 idle, 1 travelling up, 2 travelling down, 3 door open
  // m_left: cycles of the current activity still to run, including this one
  int m_floor = 0;
  int m_act   = 0;
  int m_left  = 0;
  int m_cool  = 0;
  bit m_pulse = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_floor <= 0;
      m_act   <= 0;
      m_left  <= 0;
      m_cool  <= 0;
      m_pulse <= 1'b0;
    end else begin
      m_pulse <= 1'b0;
      m_cool  <= (m_cool > 0) ? m_cool - 1 : 0;
      if (m_act == 0) begin
        if (command == 2'b11 && m_cool == 0) begin
          m_act <= 3; m_left <= DOOR;
        end else if (command == 2'b01 && m_floor < N - 1) begin
          m_act <= 1; m_left <= TRAV;
        end else if (command == 2'b10 && m_floor > 0) begin
          m_act <= 2; m_left <= TRAV;
        end
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end else begin
        m_act <= 0;
        if (m_act == 1)      m_floor <= m_floor + 1;
        else if (m_act == 2) m_floor <= m_floor - 1;
        else begin
          m_pulse <= 1'b1;
          m_cool  <= SETL;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("mdl_floor",  int'(cur_floor),    m_floor);
      check("mdl_served", int'(served_pulse), int'(m_pulse));
      check("mdl_door",   int'(door_open),    int'(m_act == 3));
      check("mdl_up",     int'(moving_up),    int'(m_act == 1));
      check("mdl_down",   int'(moving_down),  int'(m_act == 2));
      check("mdl_busy",   int'(busy),         int'(m_act != 0));
    end
  end

  // Apply reset for one edge; returns on the negedge right after release
  // is scheduled, so the next posedge is the first live edge.
  task automatic do_reset();
    rst = 1'b1;
    command = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One floor up from idle; returns at the negedge where the car has arrived.
  task automatic step_up();
    command = 2'b01;
    @(negedge clk);
    command = 2'b00;
    repeat (TRAV) @(negedge clk);
  endtask

  initial begin : stim
    int exp_f;
    int pulses;
    int gap;
    bit prev_door;

    @(negedge clk);
    cmp_en = 1'b1;
    check("reset_floor", int'(cur_floor), 0);
    check("reset_busy",  int'(busy), 0);
    check("reset_pulse", int'(served_pulse), 0);

    // 1: hold up from floor 0 to the top
    do_reset();
    command = 2'b01;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp_f = (c < 5) ? 0 : (c < 10) ? 1 : (c < 15) ? 2 : 3;
      check("s1_floor", int'(cur_floor), exp_f);
      if (c >= 15) begin
        check("s1_up_idle", int'(moving_up), 0);
        check("s1_busy_idle", int'(busy), 0);
      end
    end
    command = 2'b00;
    $display("scenario 1 hold-up done, floor %0d", cur_floor);

    // 2: down at floor 0 is ignored
    do_reset();
    command = 2'b10;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("s2_floor", int'(cur_floor), 0);
      check("s2_down", int'(moving_down), 0);
    end
    command = 2'b00;
    $display("scenario 2 down-at-bottom done");

    // 3: single serve at floor 2
    do_reset();
    step_up();
    step_up();
    check("s3_start_floor", int'(cur_floor), 2);
    command = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) command = 2'b00;
      check("s3_door", int'(door_open), int'(c >= 1 && c <= 6));
      check("s3_pulse", int'(served_pulse), int'(c == 7));
      check("s3_floor", int'(cur_floor), 2);
    end
    $display("scenario 3 single serve done");

    // 4: serve held continuously
    do_reset();
    command = 2'b11;
    pulses = 0;
    gap = 0;
    prev_door = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (served_pulse) pulses++;
      if (door_open && !prev_door && c > 1) check("s4_idle_gap", gap, 4);
      gap = door_open ? 0 : gap + 1;
      prev_door = door_open;
    end
    command = 2'b00;
    check("s4_pulses", pulses, 4);
    $display("scenario 4 held serve done, %0d pulses", pulses);

    // 5: up then down requested mid-travel from floor 1
    do_reset();
    step_up();
    command = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) command = 2'b10;
      if (c == 4) begin
        check("s5_mid_floor", int'(cur_floor), 1);
        check("s5_mid_up", int'(moving_up), 1);
      end
      if (c == 5) begin
        check("s5_arrive_floor", int'(cur_floor), 2);
        check("s5_arrive_busy", int'(busy), 0);
      end
      if (c == 6) check("s5_down_start", int'(moving_down), 1);
      if (c == 10) check("s5_back_floor", int'(cur_floor), 1);
    end
    command = 2'b00;
    $display("scenario 5 reverse done");

    // 6: reset during a door cycle at floor 3
    do_reset();
    command = 2'b01;
    repeat (15) @(negedge clk);
    command = 2'b00;
    check("s6_top_floor", int'(cur_floor), 3);
    command = 2'b11;
    @(negedge clk);
    command = 2'b00;
    check("s6_door_on", int'(door_open), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_rst_floor", int'(cur_floor), 0);
    check("s6_rst_door", int'(door_open), 0);
    check("s6_rst_busy", int'(busy), 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("s6_no_pulse", int'(served_pulse), 0);
    end
    $display("scenario 6 reset mid-door done");

    // 7: randomized commands in runs, with rare resets
    for (int i = 0; i < 3000; i++) begin
      if ((i % 3) == 0 || $urandom_range(0, 3) == 0) command = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    command = 2'b00;
    @(negedge clk);
    $display("scenario 7 random done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
